async_counter: RTL and testbench

//   4-bit asynchronous (ripple) binary up-counter for the lab datapath.

---
 rtl/async_counter_pkg.sv | 6 +
 rtl/t_flip_flop.sv | 20 ++
 rtl/async_counter.sv | 39 +++
 tb/tb_async_counter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/async_counter_pkg.sv
// Shared constants for the 4-stage ripple up-counter.
package async_counter_pkg;

  localparam int NUM_STAGES = 4;

endpackage

// File: rtl/t_flip_flop.sv
// Toggle flip-flop with T tied high: inverts on every falling edge of its stage clock.
module t_flip_flop (
  input  logic CLK,
  input  logic RST_N,
  output logic Q
);

  logic q_reg;

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= ~q_reg;
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/async_counter.sv
// 4-bit ripple up-counter: stage 0 runs on CLK, each later stage on the previous bit.
module async_counter
  import async_counter_pkg::*;
(
  input  logic CLK,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  input  logic RST_N
);

  logic [NUM_STAGES-1:0] q;

  // A bit falling 1->0 is its carry out, so negedge clocking of the next stage counts up.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        t_flip_flop u_tff (
          .CLK   (CLK),
          .RST_N (RST_N),
          .Q     (q[gi])
        );
      end else begin : g_chain
        t_flip_flop u_tff (
          .CLK   (q[gi-1]),
          .RST_N (RST_N),
          .Q     (q[gi])
        );
      end
    end
  endgenerate

  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];

endmodule

// File: tb/tb_async_counter.sv
// Directed bench for async_counter: stimulus queues expected counts, a monitor compares.
module tb_async_counter;

  logic CLK;
  logic RST_N;
  logic Q0, Q1, Q2, Q3;

  async_counter dut (
    .CLK   (CLK),
    .Q0    (Q0),
    .Q1    (Q1),
    .Q2    (Q2),
    .Q3    (Q3),
    .RST_N (RST_N)
  );

  typedef struct {
    string      name;
    logic [3:0] exp;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   errors = 0;
  int   checks = 0;

  bit count_en = 1'b0;
  int tog0 = 0, tog1 = 0, tog2 = 0, tog3 = 0;

  always @(Q0) if (count_en) tog0++;
  always @(Q1) if (count_en) tog1++;
  always @(Q2) if (count_en) tog2++;
  always @(Q3) if (count_en) tog3++;

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  // Monitor: consumes one expected entry per sample request, after ripple has settled.
  initial begin
    exp_t       e;
    logic [3:0] got;
    forever begin
      @(sample_ev);
      got = {Q3, Q2, Q1, Q0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got %b, expected no sample", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b, expected %b", e.name, got, e.exp);
        end else begin
          $display("ok   %s: %b", e.name, got);
        end
      end
    end
  end

  task automatic expect_now(input string name, input logic [3:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    #1;
    ->sample_ev;
  endtask

  // Falling edge of CLK, then check the settled count.
  task automatic drive_fall(input string name, input logic [3:0] exp);
    CLK = 1'b0;
    expect_now(name, exp);
    #24;
  endtask

  task automatic drive_rise();
    CLK = 1'b1;
    #25;
  endtask

  task automatic cycle(input string name, input logic [3:0] exp);
    drive_fall(name, exp);
    drive_rise();
  endtask

  initial begin
    CLK   = 1'b1;
    RST_N = 1'b1;
    #5;

    // 1. Reset holds zero while CLK toggles; release gives 0001 on first negedge
    RST_N = 1'b0;
    expect_now("reset_assert", 4'b0000);
    #19;
    for (int i = 0; i < 3; i++) cycle($sformatf("reset_hold_%0d", i), 4'b0000);
    #10;
    RST_N = 1'b1;
    #15;
    cycle("release_first", 4'b0001);

    // 2./3. Full count up to 1111, wrap to 0000, then 0001 and around to 1111 again
    for (int i = 2; i <= 16; i++) cycle($sformatf("count_%0d", i), 4'(i));
    for (int i = 1; i <= 15; i++) cycle($sformatf("recount_%0d", i), 4'(i));
    cycle("wrap_to_zero", 4'b0000);
    cycle("after_wrap", 4'b0001);

    // 4. Rising edge alone must not advance
    for (int i = 2; i <= 4; i++) cycle($sformatf("to_0101_%0d", i), 4'(i));
    drive_fall("at_0101", 4'b0101);
    CLK = 1'b1;
    expect_now("rise_only", 4'b0101);
    #24;
    drive_fall("fall_after_rise", 4'b0110);
    drive_rise();

    // 5. Async reset between edges at 1011
    cycle("to_0111", 4'b0111);
    cycle("to_1000", 4'b1000);
    cycle("to_1001", 4'b1001);
    cycle("to_1010", 4'b1010);
    drive_fall("at_1011", 4'b1011);
    #10;
    RST_N = 1'b0;
    expect_now("midcount_reset", 4'b0000);
    #14;
    drive_rise();
    for (int i = 0; i < 3; i++) cycle($sformatf("midreset_hold_%0d", i), 4'b0000);
    #10;
    RST_N = 1'b1;
    #15;

    // 6. Bit toggle frequencies over 32 CLK cycles
    count_en = 1'b1;
    for (int i = 1; i <= 32; i++) cycle($sformatf("freq_%0d", i), 4'(i));
    count_en = 1'b0;
    check_int("toggles_q0", tog0, 32);
    check_int("toggles_q1", tog1, 16);
    check_int("toggles_q2", tog2, 8);
    check_int("toggles_q3", tog3, 4);

    #5;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
